// File: rtl/uart_tx_fifo.sv
// Byte FIFO that feeds a UART serializer through a one-cycle start pulse and a busy handshake.
// Define UART_TXQ_STATS_EN to add the saturating dropped-write counter output drop_cnt.
module uart_tx_fifo #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [7:0]        wr_data,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   level,
    output logic              overflow,
    output logic              tx_start,
    output logic [7:0]        tx_data,
    input  logic              tx_busy
`ifdef UART_TXQ_STATS_EN
    ,
    output logic [15:0]       drop_cnt
`endif
);

    typedef enum logic [1:0] {StIdle, StWaitBusy, StWaitDone} state_e;

    localparam int unsigned   CntW    = ADDR_W + 1;
    localparam logic [ADDR_W:0] CntFull = CntW'(DEPTH);
    localparam logic [ADDR_W:0] CntOne  = CntW'(1);

    state_e            state_q;
    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q;
    logic [ADDR_W-1:0] rd_ptr_q;
    logic [ADDR_W:0]   count_q;
    logic [ADDR_W:0]   count_d;
    logic              wr_accept;
    logic              pop;

    // Both decisions use the registered flags, so a write seen while full is
    // dropped even when a pop frees a slot on the same edge.
    assign wr_accept = wr_en && !full;
    assign pop       = (state_q == StIdle) && !empty && !tx_busy;
    assign level     = count_q;

    always_comb begin
        count_d = count_q;
        if (wr_accept && !pop) begin
            count_d = count_q + CntOne;
        end else if (!wr_accept && pop) begin
            count_d = count_q - CntOne;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            overflow <= 1'b0;
            tx_start <= 1'b0;
            tx_data  <= 8'h00;
        end else begin
            tx_start <= 1'b0;
            overflow <= wr_en && full;
            count_q  <= count_d;
            full     <= (count_d == CntFull);
            empty    <= (count_d == '0);
            if (wr_accept) begin
                wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
            end
            unique case (state_q)
                StIdle: begin
                    if (pop) begin
                        tx_data  <= mem[rd_ptr_q];
                        tx_start <= 1'b1;
                        rd_ptr_q <= rd_ptr_q + ADDR_W'(1);
                        state_q  <= StWaitBusy;
                    end
                end
                StWaitBusy: begin
                    if (tx_busy) begin
                        state_q <= StWaitDone;
                    end
                end
                StWaitDone: begin
                    if (!tx_busy) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

`ifdef UART_TXQ_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt <= 16'h0000;
        end else if (wr_en && full && (drop_cnt != 16'hFFFF)) begin
            drop_cnt <= drop_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: vector table, corner-case sequences and random traffic
// checked against a queue-based reference model with a behavioural serializer busy generator.
module tb_uart_tx_fifo;

    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          clk     = 1'b0;
    logic          rst_n   = 1'b1;
    logic          wr_en   = 1'b0;
    logic [7:0]    wr_data = 8'h00;
    logic          tx_busy = 1'b0;
    logic          full;
    logic          empty;
    logic [AW:0]   level;
    logic          overflow;
    logic          tx_start;
    logic [7:0]    tx_data;
`ifdef UART_TXQ_STATS_EN
    logic [15:0]   drop_cnt;
`endif

    uart_tx_fifo #(
        .DEPTH  (DEPTH),
        .ADDR_W (AW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .full     (full),
        .empty    (empty),
        .level    (level),
        .overflow (overflow),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .tx_busy  (tx_busy)
`ifdef UART_TXQ_STATS_EN
        ,
        .drop_cnt (drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: queued bytes plus the serializer handshake status.
    logic [7:0] mq[$];
    logic [7:0] dut_log[$];
    logic       handed;
    logic       seen_busy;
    logic       m_start;
    logic       m_ovf;
    logic [7:0] m_data;
    int         m_drops;
    int         busy_left;
    bit         auto_busy;

    typedef struct {
        logic       wr;
        logic [7:0] din;
        logic       busy;
        logic       start;
        logic [7:0] dout;
        logic [4:0] lvl;
        logic       ful;
        logic       emp;
        logic       ovf;
    } vec_t;

    vec_t vt[11];

    function automatic vec_t mk(input logic wr, input logic [7:0] din, input logic busy,
                                input logic start, input logic [7:0] dout, input logic [4:0] lvl,
                                input logic ful, input logic emp, input logic ovf);
        vec_t v;
        v.wr = wr; v.din = din; v.busy = busy; v.start = start; v.dout = dout;
        v.lvl = lvl; v.ful = ful; v.emp = emp; v.ovf = ovf;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] pack_dut();
        return 32'({tx_start, tx_data, level, full, empty, overflow});
    endfunction

    function automatic logic [31:0] pack_model();
        logic [4:0] n;
        n = 5'(mq.size());
        return 32'({m_start, m_data, n, (mq.size() == DEPTH), (mq.size() == 0), m_ovf});
    endfunction

    task automatic model_reset();
        mq.delete();
        handed    = 1'b0;
        seen_busy = 1'b0;
        m_start   = 1'b0;
        m_ovf     = 1'b0;
        m_data    = 8'h00;
        m_drops   = 0;
        busy_left = 0;
    endtask

    // One clock of the spec rules, evaluated on pre-edge inputs and pre-edge occupancy.
    task automatic model_step(input logic w, input logic [7:0] d, input logic b);
        int n;
        n       = mq.size();
        m_ovf   = w && (n == DEPTH);
        m_start = 1'b0;
        if (!handed && n != 0 && !b) begin
            m_data    = mq.pop_front();
            m_start   = 1'b1;
            handed    = 1'b1;
            seen_busy = 1'b0;
        end else if (handed && !seen_busy && b) begin
            seen_busy = 1'b1;
        end else if (handed && seen_busy && !b) begin
            handed = 1'b0;
        end
        if (w && n < DEPTH) mq.push_back(d);
        if (m_ovf && m_drops < 65535) m_drops++;
    endtask

    task automatic step();
        model_step(wr_en, wr_data, tx_busy);
        @(posedge clk);
        #1;
        check("cycle", pack_dut(), pack_model());
        if (tx_start) dut_log.push_back(tx_data);
        if (auto_busy) begin
            if (busy_left > 0) begin
                tx_busy = 1'b1;
                busy_left--;
            end else begin
                tx_busy = 1'b0;
            end
            if (tx_start) busy_left = $urandom_range(1, 6);
        end
    endtask

    task automatic do_reset();
        wr_en     = 1'b0;
        wr_data   = 8'h00;
        tx_busy   = 1'b0;
        auto_busy = 1'b0;
        rst_n     = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic drain();
        wr_en = 1'b0;
        for (int k = 0; k < 1000; k++) begin
            if (mq.size() == 0 && !handed) break;
            step();
        end
        check("drain_done", 32'(empty), 32'd1);
    endtask

    initial begin
        int nxt;
        int mism;
        int starts;

        vt[0]  = mk(1'b1, 8'h55, 1'b0, 1'b0, 8'h00, 5'd1, 1'b0, 1'b0, 1'b0);
        vt[1]  = mk(1'b0, 8'h00, 1'b0, 1'b1, 8'h55, 5'd0, 1'b0, 1'b1, 1'b0);
        vt[2]  = mk(1'b1, 8'h66, 1'b0, 1'b0, 8'h55, 5'd1, 1'b0, 1'b0, 1'b0);
        vt[3]  = mk(1'b0, 8'h00, 1'b0, 1'b0, 8'h55, 5'd1, 1'b0, 1'b0, 1'b0);
        vt[4]  = mk(1'b0, 8'h00, 1'b1, 1'b0, 8'h55, 5'd1, 1'b0, 1'b0, 1'b0);
        vt[5]  = mk(1'b0, 8'h00, 1'b1, 1'b0, 8'h55, 5'd1, 1'b0, 1'b0, 1'b0);
        vt[6]  = mk(1'b0, 8'h00, 1'b0, 1'b0, 8'h55, 5'd1, 1'b0, 1'b0, 1'b0);
        vt[7]  = mk(1'b0, 8'h00, 1'b0, 1'b1, 8'h66, 5'd0, 1'b0, 1'b1, 1'b0);
        vt[8]  = mk(1'b0, 8'h00, 1'b0, 1'b0, 8'h66, 5'd0, 1'b0, 1'b1, 1'b0);
        vt[9]  = mk(1'b0, 8'h00, 1'b1, 1'b0, 8'h66, 5'd0, 1'b0, 1'b1, 1'b0);
        vt[10] = mk(1'b0, 8'h00, 1'b0, 1'b0, 8'h66, 5'd0, 1'b0, 1'b1, 1'b0);

        // Reset state, observed while reset is still asserted.
        model_reset();
        auto_busy = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("reset_state", pack_dut(), 32'({1'b0, 8'h00, 5'd0, 1'b0, 1'b1, 1'b0}));
`ifdef UART_TXQ_STATS_EN
        check("reset_drop_cnt", 32'(drop_cnt), 32'd0);
`endif
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Vector table: single write latency and handshake stepping.
        for (int i = 0; i < 11; i++) begin
            wr_en   = vt[i].wr;
            wr_data = vt[i].din;
            tx_busy = vt[i].busy;
            step();
            check($sformatf("vec%0d", i), pack_dut(),
                  32'({vt[i].start, vt[i].dout, vt[i].lvl, vt[i].ful, vt[i].emp, vt[i].ovf}));
        end

        // Fill with the serializer busy, then one write too many.
        do_reset();
        tx_busy = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            wr_en   = 1'b1;
            wr_data = 8'(8'h80 + i);
            step();
        end
        check("full_after_16", 32'({full, level}), 32'({1'b1, 5'd16}));
        wr_data = 8'hEE;
        step();
        check("overflow_pulse", 32'({overflow, level}), 32'({1'b1, 5'd16}));
        wr_en = 1'b0;
        step();
        check("overflow_one_cycle", 32'(overflow), 32'd0);
`ifdef UART_TXQ_STATS_EN
        check("drop_cnt_1", 32'(drop_cnt), 32'd1);
`endif

        // Release busy and write on the pop cycle: dropped, level 15.
        tx_busy   = 1'b0;
        auto_busy = 1'b1;
        wr_en     = 1'b1;
        wr_data   = 8'hDD;
        step();
        check("pop_cycle_write", 32'({tx_start, tx_data, level, overflow}),
              32'({1'b1, 8'h80, 5'd15, 1'b1}));
`ifdef UART_TXQ_STATS_EN
        check("drop_cnt_2", 32'(drop_cnt), 32'd2);
`endif
        drain();

        // 40 sequential bytes: pointers wrap twice, order preserved.
        do_reset();
        auto_busy = 1'b1;
        dut_log.delete();
        nxt = 0;
        for (int k = 0; k < 3000 && nxt < 40; k++) begin
            wr_en   = ($urandom_range(0, 3) != 0) && (mq.size() < DEPTH);
            wr_data = 8'(nxt);
            if (wr_en) nxt++;
            step();
        end
        drain();
        check("order_count", 32'(dut_log.size()), 32'd40);
        mism = 0;
        foreach (dut_log[i]) if (dut_log[i] != 8'(i)) mism++;
        check("order_bytes", 32'(mism), 32'd0);

        // Reset while waiting for the serializer with 5 bytes queued.
        do_reset();
        wr_en   = 1'b1;
        wr_data = 8'h11;
        step();
        wr_en = 1'b0;
        step();
        step();
        tx_busy = 1'b1;
        step();
        for (int i = 0; i < 5; i++) begin
            wr_en   = 1'b1;
            wr_data = 8'(8'h20 + i);
            step();
        end
        wr_en = 1'b0;
        check("queued_5", 32'(level), 32'd5);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("mid_reset", 32'({empty, tx_start, level}), 32'({1'b1, 1'b0, 5'd0}));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        dut_log.delete();
        starts = 0;
        for (int i = 0; i < 12; i++) begin
            tx_busy = (i < 3);
            step();
            if (tx_start) starts++;
        end
        check("no_send_after_reset", 32'(starts), 32'd0);
        wr_en   = 1'b1;
        wr_data = 8'h77;
        step();
        wr_en = 1'b0;
        step();
        check("fresh_write", 32'({tx_start, tx_data}), 32'({1'b1, 8'h77}));

        // Random traffic with overflow pressure.
        do_reset();
        auto_busy = 1'b1;
        for (int k = 0; k < 800; k++) begin
            wr_en   = ($urandom_range(0, 9) < 6);
            wr_data = 8'($urandom);
            step();
        end
        drain();
`ifdef UART_TXQ_STATS_EN
        check("drop_cnt_random", 32'(drop_cnt), 32'(m_drops));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 Parameter DEPTH, default 16, FIFO entries in bytes; SHALL be a power of two, 2..256.
REQ-002 Parameter ADDR_W, default 4, pointer width; SHALL equal log2(DEPTH).
REQ-003 clk  input  1  single system clock; all logic SHALL be on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 wr_en  input  1  byte write request from producer.
REQ-006 wr_data  input  8  byte to enqueue.
REQ-007 full  output  1  registered; high when count == DEPTH.
REQ-008 empty  output  1  registered; high when count == 0.
REQ-009 level  output  ADDR_W+1  current entry count, 0..DEPTH.
REQ-010 overflow  output  1  one-cycle pulse when a write is dropped.
REQ-011 tx_start  output  1  one-cycle start pulse to the serializer.
REQ-012 tx_data  output  8  byte presented to the serializer; held stable until the next pop.
REQ-013 tx_busy  input  1  serializer busy flag; rises the cycle after an accepted tx_start and falls after the stop bit.
REQ-014 drop_cnt  output  16  dropped-write counter; present only when UART_TXQ_STATS_EN is defined.

Function
REQ-015 Write SHALL be accepted when wr_en=1 and full=0, storing wr_data at wr_ptr; wr_ptr increments modulo DEPTH.
REQ-016 A write with full=1 SHALL be dropped, with overflow=1 in the following cycle, and storage and pointers unchanged.
REQ-017 full SHALL be evaluated on the pre-edge count: a write when full is dropped even if a pop happens in the same cycle.
REQ-018 Pop and accepted write in the same cycle SHALL leave level unchanged; otherwise level changes by exactly +1 or -1.
REQ-019 Pointers SHALL wrap from DEPTH-1 to 0 with no gap or loss; bytes SHALL leave in write order.
REQ-020 The FSM SHALL have exactly three states: IDLE, WAIT_BUSY and WAIT_DONE.
REQ-021 IDLE: when empty=0 and tx_busy=0, the block SHALL load tx_data from mem[rd_ptr], set tx_start=1, advance rd_ptr and move to WAIT_BUSY.
REQ-022 tx_start SHALL be high for exactly one cycle per pop and SHALL never be high outside the cycle after a pop.
REQ-023 WAIT_BUSY: when tx_busy=1, the FSM SHALL move to WAIT_DONE; otherwise it SHALL stay.
REQ-024 WAIT_DONE: when tx_busy=0, the FSM SHALL move to IDLE; a new pop SHALL occur no earlier than the cycle after returning to IDLE.
REQ-025 There SHALL be no fall-through: with an empty FIFO, wr_en in cycle N gives tx_start=1 in cycle N+2 (if tx_busy=0).
REQ-026 Back-to-back bytes SHALL be separated only by serializer busy time plus 2 idle cycles.

Reset
REQ-027 rst_n=0 SHALL immediately force the FSM to IDLE and clear pointers, level and drop_cnt; full=0, empty=1, overflow=0, tx_start=0, tx_data=8'h00.
REQ-028 Reset mid-transfer SHALL discard all queued bytes; after release the FSM SHALL wait in IDLE for empty=0 and tx_busy=0.
REQ-029 Memory contents need no reset.

Configuration
REQ-030 Macro UART_TXQ_STATS_EN defined: drop_cnt SHALL increment on every dropped write and saturate at 16'hFFFF.
REQ-031 Macro UART_TXQ_STATS_EN undefined: the drop_cnt port and its register SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-032 Reset, then write 8'h55 with tx_busy=0 -> tx_start pulse 2 cycles later with tx_data=8'h55; level returns to 0.
REQ-033 Write 8'h41, 8'h42, 8'h43 back-to-back with a real uart_tx (CLK_FREQ=100 MHz, 115200 baud) attached -> serial line carries 0x41, 0x42, 0x43 in order, with each start pulse only after tx_busy has fallen.
REQ-034 With tx_busy held at 1, write 17 bytes (DEPTH=16) -> full=1 after the 16th; the 17th is dropped with one overflow pulse and, with the macro, drop_cnt=1.
REQ-035 Fill the FIFO to full, then release tx_busy and write on the pop cycle -> that write is dropped and level becomes 15.
REQ-036 Cycle 40 bytes 0x00..0x27 through the FIFO -> pointers wrap twice and output order exactly matches input.
REQ-037 Assert rst_n=0 while in WAIT_DONE with 5 bytes queued -> empty=1, tx_start=0 and the FSM in IDLE; no queued byte is sent after release.
